// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache memory responder: FSM states,
// block-offset width, jitter LFSR constants and the word-index function.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam int BLOCK_OFFSET_BITS = 5;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Block address to word index; upper bits alias modulo depth (a power of two).
    function automatic logic [31:0] block_index(input logic [31:0] addr,
                                                input int unsigned depth);
        return (addr >> BLOCK_OFFSET_BITS) & (depth - 1);
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache miss-path memory bus: the cache is the master, the memory responder the slave.
interface cache_mem_responder_if;

    // Handshake: a request (mem_read or mem_write) stays high until the master
    // sees the one-cycle mem_ready strobe; rdata_mem is valid while mem_ready is high.
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic [31:0] rdata_mem;
    logic        mem_ready;

    modport master (
        output mem_read, mem_write, addr_mem, wdata_mem,
        input  rdata_mem, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, addr_mem, wdata_mem,
        output rdata_mem, mem_ready
    );

endinterface

// File: rtl/cache_mem_lfsr16.sv
// 16-bit Fibonacci LFSR advancing every cycle; supplies latency jitter
// to the memory responder when MEM_RESP_JITTER_EN is defined.
module cache_mem_lfsr16
    import cache_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache miss path: fixed-latency word store with
// IDLE/WAIT/RESP/TURN handshake. Define MEM_RESP_JITTER_EN for LFSR latency jitter.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int          MEM_DEPTH    = 1024,
    parameter int          LATENCY      = 3,
    parameter logic [31:0] INIT_PATTERN = 32'hA5A5_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_mem_responder_if.slave   bus,
    output state_t                 o_dbg_state
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY + 4);

    typedef logic [MEM_DEPTH-1:0][31:0] mem_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            m[i] = INIT_PATTERN ^ 32'(i);
        end
        return m;
    endfunction

    // Contents come from the power-up value only; reset never touches them.
    mem_t r_mem = init_mem();

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_op_wr;
    logic [IW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [CW-1:0]   r_cnt;

    logic            w_req;
    logic            w_op_req;
    logic [IW-1:0]   w_req_idx;
    logic [CW-1:0]   w_load_val;

    assign w_req     = bus.mem_write | bus.mem_read;
    assign w_op_req  = r_op_wr ? bus.mem_write : bus.mem_read;
    assign w_req_idx = IW'(block_index(bus.addr_mem, MEM_DEPTH));

`ifdef MEM_RESP_JITTER_EN
    logic [15:0] w_lfsr;

    cache_mem_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    assign w_load_val = CW'(LATENCY - 1) + CW'(w_lfsr[1:0]);
`else
    assign w_load_val = CW'(LATENCY - 1);
`endif

    // A dropped request in WAIT is an abort; TURN swallows the write-back tail cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_req) w_state_nxt = WAIT;
            WAIT: begin
                if (!w_op_req) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_req) begin
                r_op_wr <= bus.mem_write;
                r_idx   <= w_req_idx;
                r_wdata <= bus.wdata_mem;
                r_cnt   <= w_load_val;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == WAIT && w_state_nxt == RESP && !r_op_wr) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Write commits on the RESP->TURN edge, so a following read sees it.
    always_ff @(posedge clk) begin
        if (r_state == RESP && r_op_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.mem_ready = (r_state == RESP);
    assign bus.rdata_mem = r_rdata;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory-side responder for the cache host's miss path. It services the cache's `mem_read` / `mem_write` requests over the `addr_mem` / `wdata_mem` / `rdata_mem` / `mem_ready` interface.
- Backing store: a word array indexed by block address, with a fixed, parameterised access latency.
- Used as the memory model in cache-host benches and as a synthesizable memory stub in host integrations.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- LATENCY, 3, WAIT cycles between request acceptance and `mem_ready`; at least 1.
- INIT_PATTERN, 32'hA5A5_0000, initial content of word i is INIT_PATTERN ^ i (set by initial block; not affected by reset).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  read request; held high by the cache until it sees `mem_ready`.
- mem_write  in  1  write-back request; held high until `mem_ready`, and may stay high one extra cycle after it.
- addr_mem  in  32  block address; bits [4:0] are ignored.
- wdata_mem  in  32  write data.
- rdata_mem  out  32  read data; valid while `mem_ready` is high.
- mem_ready  out  1  one-cycle completion strobe.

Behaviour:
- Word index = addr_mem[$clog2(MEM_DEPTH)+4:5]. Higher address bits are ignored, so addresses alias modulo MEM_DEPTH blocks.
- Reset (async assert, sync-safe deassert):
  - state = IDLE, `mem_ready` = 0, `rdata_mem` = 0, counter = 0.
  - Array contents are retained.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - If `mem_write` or `mem_read` is sampled high, latch op, index and `wdata_mem`; load counter = LATENCY-1; go to WAIT.
  - Write has priority when both are high. The read is not dropped; it is serviced afterwards if still held.
- WAIT:
  - If the latched op's request signal is low, it is an abort: go to IDLE, no array write, no `mem_ready`.
  - Otherwise, if counter == 0, go to RESP; else decrement the counter.
- RESP:
  - `mem_ready` = 1 (Moore decode of state).
  - Read: `rdata_mem` is loaded from the array on the WAIT→RESP edge, so it is valid throughout RESP.
  - Write: array[index] <= latched wdata at the end of the RESP cycle.
  - Always go to TURN next.
- TURN:
  - Ignore all requests for exactly one cycle, absorbing the cache's trailing `mem_write` cycle after write-back; then go to IDLE.
- `rdata_mem` holds its last read value until the next read completes; writes never change it.
- Timing: request first sampled in IDLE at cycle c → `mem_ready` high at cycle c+LATENCY+1 for exactly one cycle. Minimum request-to-request spacing is LATENCY+3 cycles.
- Read-after-write to the same index: the read returns the newly written data, since the write commits before TURN.
- Address or data changes while in WAIT are ignored; the values latched in IDLE are used.
- Reset during WAIT/RESP: the transaction is lost, with no array write unless the RESP edge has already occurred.

Optional Feature:
- Macro: MEM_RESP_JITTER_EN.
- With it defined:
  - Add a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advancing every cycle.
  - Counter load in IDLE = LATENCY-1 + lfsr[1:0], giving variable latency from LATENCY+1 to LATENCY+4.
- Without it: fixed latency, no LFSR logic.

Decomposition:
- Shared package cache_mem_pkg:
  - state enum (IDLE, WAIT, RESP, TURN);
  - BLOCK_OFFSET_BITS = 5;
  - LFSR seed and tap constants;
  - index-extraction function.
- One natural sub-module: cache_mem_lfsr16, instantiated only under MEM_RESP_JITTER_EN.

Test Plan:
- Reset, then read addr 32'h0000_0040 held high (LATENCY=3, no jitter) → `mem_ready` high exactly 4 cycles after first sample; `rdata_mem` = 32'hA5A5_0002; request released → no second `mem_ready`.
- Write 32'hDEAD_BEEF to 32'h0000_0060 held 1 cycle past `mem_ready` → one strobe only, TURN absorbs the tail. Then read same addr → 32'hDEAD_BEEF.
- `mem_read` and `mem_write` both high in IDLE, different addresses → write completes first, then the held read completes after TURN+IDLE.
- Read addr 32'h0000_8040 with MEM_DEPTH=1024 → aliases to index 2; returns the same data as 32'h0000_0040.
- Abort: `mem_write` dropped after 1 WAIT cycle → no `mem_ready`, target word unchanged; `rst_n` pulsed mid-WAIT → `mem_ready` = 0 and `rdata_mem` = 0 immediately, array intact.
- MEM_RESP_JITTER_EN defined, 100 back-to-back reads → every latency within 4..7 cycles and data always correct.
